// File: rtl/core_branch_predict_pkg.sv
// Shared types and constants for the next-PC selection unit and its BTB.
package core_branch_predict_pkg;

  localparam int BP_XLEN = 64;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Tag and target are stored at full width; only the live bits are compared.
  typedef struct packed {
    logic               valid;
    logic [BP_XLEN-1:0] tag;
    logic [BP_XLEN-1:0] target;
    logic [1:0]         ctr;
  } btb_entry_t;

  typedef enum logic [2:0] {
    PC_RESET, PC_HANDLER, PC_ERET, PC_MISPRED, PC_J, PC_JR, PC_PRED, PC_SEQ
  } pc_sel_t;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    end else begin
      res = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/core_branch_predict_if.sv
// Pipeline-facing signal bundle for the next-PC selection unit.
interface core_branch_predict_if #(parameter int XLEN = 64);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pc4;
  logic            take_handler;
  logic            eret;
  logic [XLEN-1:0] epc;
  logic            id_jump;
  logic [XLEN-1:0] id_jump_addr;
  logic            id_jr;
  logic [XLEN-1:0] id_jr_addr;
  logic            ex_branch;
  logic            ex_taken;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  logic [XLEN-1:0] next_pc;
  logic            flush;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic [31:0]     mispredict_cnt;

  modport master (
    output fetch_pc, pc4, take_handler, eret, epc, id_jump, id_jump_addr,
           id_jr, id_jr_addr, ex_branch, ex_taken, ex_pc, ex_target,
           ex_pred_taken, ex_pred_target,
    input  next_pc, flush, pred_taken, pred_target, mispredict_cnt
  );

  modport slave (
    input  fetch_pc, pc4, take_handler, eret, epc, id_jump, id_jump_addr,
           id_jr, id_jr_addr, ex_branch, ex_taken, ex_pc, ex_target,
           ex_pred_taken, ex_pred_target,
    output next_pc, flush, pred_taken, pred_target, mispredict_cnt
  );

endinterface

// File: rtl/core_btb.sv
// Direct-mapped branch target buffer: combinational lookup at fetch,
// registered counter/target update from the EX-stage branch resolution.
module core_btb
  import core_branch_predict_pkg::*;
#(
  parameter int XLEN        = BP_XLEN,
  parameter int BTB_ENTRIES = 16,
  parameter int IDX_W       = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] lookup_pc_i,
  input  logic [XLEN-1:0] lookup_pc4_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            upd_en_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i
);

  btb_entry_t btb_q [BTB_ENTRIES];

  logic [IDX_W-1:0] lk_idx_s;
  logic [IDX_W-1:0] up_idx_s;
  btb_entry_t       lk_entry_s;
  btb_entry_t       up_entry_s;
  btb_entry_t       wr_entry_s;
  logic             lk_hit_s;
  logic             up_hit_s;
  logic             wr_en_s;
  logic             unused_pc_bits_s;

  assign unused_pc_bits_s = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

  assign lk_idx_s   = lookup_pc_i[IDX_W+1:2];
  assign up_idx_s   = upd_pc_i[IDX_W+1:2];
  assign lk_entry_s = btb_q[lk_idx_s];
  assign up_entry_s = btb_q[up_idx_s];
  assign lk_hit_s   = lk_entry_s.valid && (lk_entry_s.tag == BP_XLEN'(lookup_pc_i[XLEN-1:IDX_W+2]));
  assign up_hit_s   = up_entry_s.valid && (up_entry_s.tag == BP_XLEN'(upd_pc_i[XLEN-1:IDX_W+2]));

  // Reads see the stored array, so a same-cycle update is invisible here.
  always_comb begin
    pred_taken_o  = 1'b0;
    pred_target_o = lookup_pc4_i;
    if (reset && lk_hit_s) begin
      pred_taken_o  = lk_entry_s.ctr[1];
      pred_target_o = lk_entry_s.target[XLEN-1:0];
    end else begin
      pred_taken_o  = 1'b0;
      pred_target_o = lookup_pc4_i;
    end
  end

  always_comb begin
    wr_en_s    = 1'b0;
    wr_entry_s = up_entry_s;
    if (upd_en_i && up_hit_s) begin
      wr_en_s        = 1'b1;
      wr_entry_s.ctr = ctr_next(up_entry_s.ctr, upd_taken_i);
      if (upd_taken_i) begin
        wr_entry_s.target = BP_XLEN'(upd_target_i);
      end else begin
        wr_entry_s.target = up_entry_s.target;
      end
    end else if (upd_en_i && upd_taken_i) begin
      wr_en_s    = 1'b1;
      wr_entry_s = '{valid: 1'b1, tag: BP_XLEN'(upd_pc_i[XLEN-1:IDX_W+2]),
                     target: BP_XLEN'(upd_target_i), ctr: CTR_WT};
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Storage: cleared by reset, which also suppresses that cycle's update.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
      end
    end else if (wr_en_s) begin
      btb_q[up_idx_s] <= wr_entry_s;
    end
  end

endmodule

// File: rtl/core_branch_predict.sv
// Next-PC selection: fixed priority redirect chain, BTB-based fetch
// prediction and a saturating EX mispredict counter.
module core_branch_predict
  import core_branch_predict_pkg::*;
#(
  parameter int          XLEN         = BP_XLEN,
  parameter int          BTB_ENTRIES  = 16,
  parameter logic [63:0] HANDLER_ADDR = 64'h0
) (
  input  logic              clock,
  input  logic              reset,
  core_branch_predict_if.slave bp
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

  logic            pred_taken_s;
  logic [XLEN-1:0] pred_target_s;
  logic            mispredict_s;
  logic [XLEN-1:0] redirect_s;
  pc_sel_t         sel_s;
  logic [XLEN-1:0] next_pc_s;
  logic            flush_s;
  logic [31:0]     cnt_q;
  logic [31:0]     cnt_d;

  core_btb #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES),
    .IDX_W       (IDX_W)
  ) u_btb (
    .clock         (clock),
    .reset         (reset),
    .lookup_pc_i   (bp.fetch_pc),
    .lookup_pc4_i  (bp.pc4),
    .pred_taken_o  (pred_taken_s),
    .pred_target_o (pred_target_s),
    .upd_en_i      (bp.ex_branch),
    .upd_pc_i      (bp.ex_pc),
    .upd_taken_i   (bp.ex_taken),
    .upd_target_i  (bp.ex_target)
  );

  assign mispredict_s = bp.ex_branch &&
                        ((bp.ex_taken != bp.ex_pred_taken) ||
                         (bp.ex_taken && (bp.ex_target != bp.ex_pred_target)));
  assign redirect_s   = bp.ex_taken ? bp.ex_target : (bp.ex_pc + PC_STEP);

  // First matching source wins.
  always_comb begin
    sel_s = PC_SEQ;
    if (!reset)                sel_s = PC_RESET;
    else if (bp.take_handler)  sel_s = PC_HANDLER;
    else if (bp.eret)          sel_s = PC_ERET;
    else if (mispredict_s)     sel_s = PC_MISPRED;
    else if (bp.id_jump)       sel_s = PC_J;
    else if (bp.id_jr)         sel_s = PC_JR;
    else if (pred_taken_s)     sel_s = PC_PRED;
    else                       sel_s = PC_SEQ;
  end

  always_comb begin
    next_pc_s = bp.pc4;
    flush_s   = 1'b0;
    case (sel_s)
      PC_RESET:   begin next_pc_s = '0;                        flush_s = 1'b1; end
      PC_HANDLER: begin next_pc_s = HANDLER_ADDR[XLEN-1:0];    flush_s = 1'b1; end
      PC_ERET:    begin next_pc_s = bp.epc;                    flush_s = 1'b1; end
      PC_MISPRED: begin next_pc_s = redirect_s;                flush_s = 1'b1; end
      PC_J:       begin next_pc_s = bp.id_jump_addr;           flush_s = 1'b1; end
      PC_JR:      begin next_pc_s = bp.id_jr_addr;             flush_s = 1'b1; end
      PC_PRED:    begin next_pc_s = pred_target_s;             flush_s = 1'b0; end
      default:    begin next_pc_s = bp.pc4;                    flush_s = 1'b0; end
    endcase
  end

  always_comb begin
    if (mispredict_s && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Mispredict counter register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bp.next_pc        = next_pc_s;
  assign bp.flush          = flush_s;
  assign bp.pred_taken     = pred_taken_s;
  assign bp.pred_target    = pred_target_s;
  assign bp.mispredict_cnt = cnt_q;

endmodule

// File: doc/core_branch_predict.md
Name: core_branch_predict

Overview:
- Next-generation next-PC selection unit for the 5-stage core.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so taken conditional branches can be redirected at fetch instead of waiting for EX.
- Keeps the existing priority chain: reset, interrupt handler, ERET, EX-stage mispredict, ID-stage J/JR, prediction, pc4.
- The handler address is a parameter; the block does no file I/O.

Parameters:
- XLEN, 64, address/data width.
- BTB_ENTRIES, 16, number of BTB entries; power of two, at least 2.
- HANDLER_ADDR, 64'h0, interrupt handler entry address, truncated to XLEN.
- IDX_W, $clog2(BTB_ENTRIES), derived; never overridden.

Ports:
- clock  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- fetch_pc  in  XLEN  PC of the instruction being fetched this cycle.
- pc4  in  XLEN  fetch_pc+4.
- take_handler  in  1  exception/interrupt taken this cycle.
- eret  in  1  ERET in ID.
- epc  in  XLEN  ERET return address.
- id_jump  in  1  J-type in ID.
- id_jump_addr  in  XLEN  J target.
- id_jr  in  1  JR in ID.
- id_jr_addr  in  XLEN  JR target (register A data).
- ex_branch  in  1  conditional branch (BEQ/BNE/BC) resolved in EX.
- ex_taken  in  1  actual outcome.
- ex_pc  in  XLEN  branch PC.
- ex_target  in  XLEN  actual branch target.
- ex_pred_taken  in  1  prediction carried with the branch.
- ex_pred_target  in  XLEN  predicted target carried with the branch.
- next_pc  out  XLEN  PC to fetch next cycle.
- flush  out  1  squash younger instructions in IF/ID (and ID/EX for EX redirect).
- pred_taken  out  1  prediction for fetch_pc, to pipeline.
- pred_target  out  XLEN  predicted target for fetch_pc, to pipeline.
- mispredict_cnt  out  32  saturating count of EX mispredicts.

Behaviour:
- BTB entry fields: valid, tag (fetch_pc[XLEN-1:IDX_W+2]), target[XLEN], ctr[2]. Index is pc[IDX_W+1:2].
- Lookup is combinational, read-before-write.
  - hit = valid && tag matches.
  - pred_taken = hit && ctr[1]; pred_target = entry target when hit, else pc4.
- Mispredict (EX, combinational) when ex_branch && either:
  - ex_taken != ex_pred_taken, or
  - ex_taken && ex_target != ex_pred_target.
- Redirect address on mispredict: ex_taken ? ex_target : ex_pc+4.
- next_pc/flush priority, first match wins:
  1. reset==0 → 0 / 1.
  2. take_handler → HANDLER_ADDR / 1.
  3. eret → epc / 1.
  4. mispredict → redirect address / 1.
  5. id_jump → id_jump_addr / 1.
  6. id_jr → id_jr_addr / 1.
  7. pred_taken → pred_target / 0. Predicted fetch redirect needs no squash.
  8. otherwise → pc4 / 0.
- A correctly predicted branch (taken or not) produces no flush in EX.
- BTB update, registered and applied on the clock edge when ex_branch=1 (regardless of priority winner):
  - Hit at index(ex_pc): ctr saturating inc if taken, dec if not (00↔11 bounded). If taken, target←ex_target.
  - Miss and taken: allocate (overwrite) with valid=1, tag, target=ex_target, ctr=2'b10.
  - Miss and not taken: no write.
- The update is visible to lookups from the next cycle; a same-cycle lookup of the same index sees the old entry.
- mispredict_cnt increments by 1 per mispredict and saturates at 32'hFFFF_FFFF.
- Reset (synchronous, mid-operation included):
  - all valid←0, ctr←2'b01, target/tag←0, mispredict_cnt←0.
  - Update suppressed in the reset cycle.
  - pred_taken=0, pred_target=pc4 while reset is asserted.
- After deassertion, all lookups miss until an allocation occurs.
- Aliasing: a tag mismatch is a miss; no partial-tag matching.

Decomposition:
- structures package gains:
  - btb_entry_t packed struct {valid, tag, target, ctr}.
  - 2-bit counter constants CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11.
  - pc_sel_t enum {PC_RESET, PC_HANDLER, PC_ERET, PC_MISPRED, PC_J, PC_JR, PC_PRED, PC_SEQ} for debug/trace.
- One sub-module: core_btb, holding storage, lookup and update. The top holds the priority mux and counter.

Test Plan:
- Reset with reset=0 for 2 cycles, fetch_pc=0x40 → next_pc=0, flush=1, pred_taken=0. After release, lookup at 0x40 → pred_taken=0, next_pc=0x44, flush=0.
- Cold taken branch: ex_branch=1, ex_pc=0x100, ex_taken=1, ex_target=0x200, ex_pred_taken=0 → next_pc=0x200, flush=1, mispredict_cnt=1. Next cycle fetch_pc=0x100 → pred_taken=1, next_pc=0x200, flush=0.
- Counter training: from ctr=10, two not-taken resolutions at 0x100 with matching predictions → first is a mispredict (redirect 0x104), ctr→01. Then fetch 0x100 predicts not-taken; second resolution matches, ctr→00, no flush.
- Aliasing: BTB_ENTRIES=16, entry for 0x100 valid; fetch_pc=0x140 (same index, different tag) → pred_taken=0, next_pc=0x144.
- Priority: take_handler=1, eret=1, mispredict and id_jump all in the same cycle, HANDLER_ADDR=0x8000 → next_pc=0x8000, flush=1, and the BTB update for the EX branch still occurs.
- Target mismatch: hit predicts 0x200 but ex_target=0x300, taken → redirect to 0x300, flush=1, entry target updated to 0x300.
